// File: rtl/pmem_line_responder_if.sv
// Physical-memory line bus between the cache (master) and a line responder (slave).
// Carries 128-bit line reads and writes with a single-cycle completion pulse.
interface pmem_line_responder_if;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   modport master (
      output pmem_read,
      output pmem_write,
      output pmem_address,
      output pmem_wdata,
      input  pmem_rdata,
      input  pmem_resp
   );

   modport slave (
      input  pmem_read,
      input  pmem_write,
      input  pmem_address,
      input  pmem_wdata,
      output pmem_rdata,
      output pmem_resp
   );
endinterface

// File: rtl/pmem_line_responder.sv
// Memory-side line responder: services 128-bit line reads/writes after LATENCY cycles.
// Optional PMEM_STATS_EN adds saturating completed-read/write counters.
module pmem_line_responder #(
   parameter int LATENCY        = 4,
   parameter int LINE_ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pmem_line_responder_if.slave pmem
`ifdef PMEM_STATS_EN
   ,
   output logic [15:0]          pmem_rd_count,
   output logic [15:0]          pmem_wr_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t                    state;
   state_t                    state_nxt;
   logic [3:0]                cnt;
   logic [3:0]                cnt_nxt;
   logic                      op_wr;
   logic                      op_wr_nxt;
   logic [LINE_ADDR_BITS-1:0] idx;
   logic [LINE_ADDR_BITS-1:0] idx_nxt;
   logic                      req;
   logic                      rd_load;
   logic [127:0]              rdata;
   logic [127:0]              mem [2**LINE_ADDR_BITS];
   logic                      addr_unused;

   assign req         = pmem.pmem_read | pmem.pmem_write;
   assign addr_unused = ^{pmem.pmem_address[15:LINE_ADDR_BITS+4],
                          pmem.pmem_address[3:0]};

   // Next-state: accept, count down, abort on dropped request, pulse resp
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_wr_nxt = op_wr;
      idx_nxt   = idx;
      unique case (state)
         IDLE: begin
            if (req) begin
               op_wr_nxt = pmem.pmem_write;
               idx_nxt   = pmem.pmem_address[LINE_ADDR_BITS+3:4];
               cnt_nxt   = CNT_INIT;
               state_nxt = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (!req) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign rd_load        = (state_nxt == RESP) && !op_wr_nxt;
   assign pmem.pmem_resp = (state == RESP);
   assign pmem.pmem_rdata = rdata;

   // Control state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         op_wr <= 1'b0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         op_wr <= op_wr_nxt;
         idx   <= idx_nxt;
      end
   end

   // Read data is captured on entry to RESP and held until the next read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (rd_load) begin
         rdata <= mem[idx_nxt];
      end
   end

   // Line array is never cleared; a write commits only at the end of RESP
   always_ff @(posedge clk) begin
      if ((state == RESP) && op_wr) begin
         mem[idx] <= pmem.pmem_wdata;
      end
   end

`ifdef PMEM_STATS_EN
   // Saturating counts of completed reads and writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pmem_rd_count <= '0;
         pmem_wr_count <= '0;
      end else if (state == RESP) begin
         if (op_wr) begin
            if (pmem_wr_count != 16'hFFFF) begin
               pmem_wr_count <= pmem_wr_count + 16'd1;
            end
         end else begin
            if (pmem_rd_count != 16'hFFFF) begin
               pmem_rd_count <= pmem_rd_count + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: LATENCY=4 and LATENCY=1 instances against a
// transaction-level model (line array, scheduled resp cycles, held read data).
module tb_pmem_line_responder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pmem_line_responder_if p4 ();
   pmem_line_responder_if p1 ();

`ifdef PMEM_STATS_EN
   logic [15:0] rc4, wc4, rc1, wc1;
`endif

   pmem_line_responder #(.LATENCY(4), .LINE_ADDR_BITS(8)) u_dut4 (
      .clk          (clk),
      .reset_n      (reset_n),
      .pmem         (p4)
`ifdef PMEM_STATS_EN
      ,
      .pmem_rd_count(rc4),
      .pmem_wr_count(wc4)
`endif
   );

   pmem_line_responder #(.LATENCY(1), .LINE_ADDR_BITS(8)) u_dut1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .pmem         (p1)
`ifdef PMEM_STATS_EN
      ,
      .pmem_rd_count(rc1),
      .pmem_wr_count(wc1)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit started = 1'b0;

   bit           exp_resp [longint];
   logic [127:0] rd_upd [longint];
   logic [127:0] mem_m [2][256];
   logic [127:0] exp_rd [2];
   int           resp_seen [2];
   int           last_resp [2];
   int           rdc [2];
   int           wrc [2];

   function automatic longint key(int d, int c);
      return longint'(d) * 64'd1000000 + longint'(c);
   endfunction

   function automatic int lat(int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(int d, bit rd, bit wr, logic [15:0] a,
                        logic [127:0] wd);
      if (d == 0) begin
         p4.pmem_read    = rd;
         p4.pmem_write   = wr;
         p4.pmem_address = a;
         p4.pmem_wdata   = wd;
      end else begin
         p1.pmem_read    = rd;
         p1.pmem_write   = wr;
         p1.pmem_address = a;
         p1.pmem_wdata   = wd;
      end
   endtask

   // One transaction; hold = edges the request stays high (>= LATENCY completes)
   task automatic op(int d, bit rd, bit wr, logic [15:0] a,
                     logic [127:0] wd, int hold);
      int k;
      int L;
      int idx;
      k   = cyc;
      L   = lat(d);
      idx = int'(a[11:4]);
      drive(d, rd, wr, a, wd);
      if (!(rd | wr)) begin
         @(posedge clk);
         #1;
         return;
      end
      if (hold >= L) begin
         exp_resp[key(d, k + L)] = 1'b1;
         if (!wr) rd_upd[key(d, k + L)] = mem_m[d][idx];
         @(posedge clk);
         #1;
         if (L > 1) drive(d, rd, wr, 16'($urandom), wd);
         repeat (L - 1) @(posedge clk);
         #1;
         drive(d, 1'b0, 1'b0, a, wd);
         @(posedge clk);
         #1;
         if (wr) begin
            mem_m[d][idx] = wd;
            wrc[d]++;
         end else begin
            rdc[d]++;
         end
      end else begin
         repeat (hold) @(posedge clk);
         #1;
         drive(d, 1'b0, 1'b0, a, wd);
         repeat (2) @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle comparison of resp and rdata against the model
   always @(negedge clk) begin : cmp
      logic         r;
      logic [127:0] rd;
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            r  = (d == 0) ? p4.pmem_resp : p1.pmem_resp;
            rd = (d == 0) ? p4.pmem_rdata : p1.pmem_rdata;
            if (rd_upd.exists(key(d, cyc))) exp_rd[d] = rd_upd[key(d, cyc)];
            check($sformatf("resp_L%0d_c%0d", lat(d), cyc), 128'(r),
                  128'(exp_resp.exists(key(d, cyc))));
            check($sformatf("rdata_L%0d_c%0d", lat(d), cyc), rd, exp_rd[d]);
            if (r === 1'b1) begin
               resp_seen[d]++;
               last_resp[d] = cyc;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d0, d1, d2, d3;
      int t0, n, k;
      d0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      d1 = 128'hFEED_FACE_CAFE_BEEF_1234_5678_9ABC_DEF0;
      d2 = 128'hDEAD_0100_0000_0000_0000_0000_0000_0001;
      d3 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
      for (int d = 0; d < 2; d++) begin
         exp_rd[d] = '0;
         resp_seen[d] = 0;
         last_resp[d] = 0;
         rdc[d] = 0;
         wrc[d] = 0;
         drive(d, 1'b0, 1'b0, 16'h0, '0);
      end
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      started = 1'b1;
      check("reset_resp4", 128'(p4.pmem_resp), 128'h0);
      check("reset_rdata4", p4.pmem_rdata, 128'h0);
      check("reset_resp1", 128'(p1.pmem_resp), 128'h0);
      check("reset_rdata1", p1.pmem_rdata, 128'h0);

      fork
         for (int i = 0; i < 256; i++)
            op(0, 1'b0, 1'b1, 16'(i << 4), rnd128(), 4);
         for (int i = 0; i < 256; i++)
            op(1, 1'b0, 1'b1, 16'(i << 4), rnd128(), 1);
      join

      t0 = cyc;
      op(0, 1'b0, 1'b1, 16'h0040, d0, 4);
      check("wr_latency", 128'(last_resp[0] - t0), 128'd4);
      n = resp_seen[0];
      t0 = cyc;
      op(0, 1'b1, 1'b0, 16'h004E, '0, 4);
      check("rd_latency", 128'(last_resp[0] - t0), 128'd4);
      check("rd_data", p4.pmem_rdata, d0);
      check("rd_pulses", 128'(resp_seen[0] - n), 128'd1);

      op(0, 1'b0, 1'b1, 16'h1230, d1, 4);
      op(0, 1'b1, 1'b0, 16'h0230, '0, 4);
      check("alias_rd", p4.pmem_rdata, d1);
      op(0, 1'b1, 1'b0, 16'h0240, '0, 4);
      checks++;
      if (p4.pmem_rdata === d1) begin
         failures++;
         $display("FAIL alias_other actual=%h required=not %h",
                  p4.pmem_rdata, d1);
      end

      n = resp_seen[0];
      op(0, 1'b1, 1'b1, 16'h0080, 128'hA5, 4);
      check("rw_pulses", 128'(resp_seen[0] - n), 128'd1);
      op(0, 1'b1, 1'b0, 16'h0080, '0, 4);
      check("rw_read", p4.pmem_rdata, 128'hA5);

      op(0, 1'b0, 1'b1, 16'h0100, d2, 4);
      op(0, 1'b1, 1'b0, 16'h0100, '0, 4);
      n = resp_seen[0];
      op(0, 1'b0, 1'b1, 16'h0100, d3, 2);
      check("abort_pulses", 128'(resp_seen[0] - n), 128'd0);
      check("abort_rdata", p4.pmem_rdata, d2);
      op(0, 1'b1, 1'b0, 16'h0100, '0, 4);
      check("abort_old", p4.pmem_rdata, d2);

      op(0, 1'b1, 1'b0, 16'h0040, '0, 4);
      check("pre_reset_rd", p4.pmem_rdata, d0);
      drive(0, 1'b1, 1'b0, 16'h0040, '0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b0;
      exp_resp.delete();
      rd_upd.delete();
      for (int d = 0; d < 2; d++) begin
         exp_rd[d] = '0;
         rdc[d] = 0;
         wrc[d] = 0;
      end
      #1;
      check("midreset_resp", 128'(p4.pmem_resp), 128'h0);
      check("midreset_rdata", p4.pmem_rdata, 128'h0);
      drive(0, 1'b0, 1'b0, 16'h0040, '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      op(0, 1'b1, 1'b0, 16'h0040, '0, 4);
      check("post_reset_rd", p4.pmem_rdata, d0);

      n = resp_seen[1];
      k = cyc;
      for (int j = 0; j < 3; j++) begin
         exp_resp[key(1, k + 1 + 2 * j)] = 1'b1;
         rd_upd[key(1, k + 1 + 2 * j)] = mem_m[1][5];
      end
      drive(1, 1'b1, 1'b0, 16'h0050, '0);
      repeat (5) @(posedge clk);
      #1;
      drive(1, 1'b0, 1'b0, 16'h0050, '0);
      repeat (2) @(posedge clk);
      #1;
      rdc[1] += 3;
      check("b2b_pulses", 128'(resp_seen[1] - n), 128'd3);
`ifdef PMEM_STATS_EN
      check("b2b_rd_count", 128'(rc1), 128'd3);
      check("b2b_wr_count", 128'(wc1), 128'd0);
`endif

      fork
         for (int i = 0; i < 120; i++) begin
            bit rd, wr;
            int h;
            rd = 1'($urandom);
            wr = ($urandom % 3) == 0;
            h = (($urandom % 5) == 0) ? int'($urandom_range(3, 1)) : 4;
            op(0, rd, wr, 16'($urandom), rnd128(), h);
         end
         for (int i = 0; i < 120; i++) begin
            bit rd, wr;
            rd = 1'($urandom);
            wr = ($urandom % 3) == 0;
            op(1, rd, wr, 16'($urandom), rnd128(), 1);
         end
      join
      repeat (2) @(posedge clk);
      #1;
`ifdef PMEM_STATS_EN
      check("rd_count4", 128'(rc4), 128'(rdc[0]));
      check("wr_count4", 128'(wc4), 128'(wrc[0]));
      check("rd_count1", 128'(rc1), 128'(rdc[1]));
      check("wr_count1", 128'(wc1), 128'(wrc[1]));
`endif
      started = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
